rv32i_id_ex_stage: RTL and testbench

//  Decode-to-execute issue stage placed directly upstream of the RV32I ALU.

---
 rtl/rv32i_id_ex_stage.sv | 209 ++++++++++++++++++++
 tb/tb_rv32i_id_ex_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_id_ex_stage.sv
// RV32I decode-to-execute issue stage: decodes the instruction into an ALU op,
// resolves forwarded operands and holds the result in the ID/EX register.
module rv32i_id_ex_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        fwd_mem_we,
  input  logic [4:0]  fwd_mem_rd,
  input  logic [31:0] fwd_mem_data,
  input  logic        fwd_wb_we,
  input  logic [4:0]  fwd_wb_rd,
  input  logic [31:0] fwd_wb_data,
  input  logic        ex_load_valid,
  input  logic [4:0]  ex_load_rd,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_alu_op,
  output logic [31:0] out_alu_a,
  output logic [31:0] out_alu_b,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic        out_rd_we,
  output logic [31:0] out_pc,
  output logic        out_is_branch,
  output logic        out_illegal
);

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [4:0] AluAdd = 5'b00000;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic        f7b;
  logic [6:0]  f7;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [4:0]  rd_idx;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] src1;
  logic [31:0] src2;

  logic        uses_rs1;
  logic        uses_rs2;
  logic        hazard;
  logic [4:0]  dec_op;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic        dec_we;
  logic        dec_branch;
  logic        dec_illegal;

  assign opcode  = in_instr[6:0];
  assign f3      = in_instr[14:12];
  assign f7      = in_instr[31:25];
  assign f7b     = in_instr[30];
  assign rs1_idx = in_instr[19:15];
  assign rs2_idx = in_instr[24:20];
  assign rd_idx  = in_instr[11:7];
  assign imm_i   = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_u   = {in_instr[31:12], 12'b0};

  // Operand source priority: youngest producer (EX/MEM) first, then MEM/WB, then regfile.
  function automatic logic [31:0] resolve(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) begin
      return 32'd0;
    end else if (fwd_mem_we && fwd_mem_rd == idx) begin
      return fwd_mem_data;
    end else if (fwd_wb_we && fwd_wb_rd == idx) begin
      return fwd_wb_data;
    end else begin
      return rf;
    end
  endfunction

  assign src1 = resolve(rs1_idx, rs1_data);
  assign src2 = resolve(rs2_idx, rs2_data);

  // Instruction decode into ALU op, operands and control flags.
  always_comb begin
    dec_op      = AluAdd;
    dec_a       = 32'd0;
    dec_b       = 32'd0;
    dec_we      = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    unique case (opcode)
      OpcOp: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          dec_op   = {1'b0, f7b, f3};
          dec_a    = src1;
          dec_b    = src2;
          dec_we   = 1'b1;
          uses_rs1 = 1'b1;
          uses_rs2 = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpcOpImm: begin
        dec_op   = {1'b0, (f3 == 3'b101) ? f7b : 1'b0, f3};
        dec_a    = src1;
        // Shift-immediates take only the 5-bit shamt; the upper imm bits select SRL/SRA.
        dec_b    = (f3 == 3'b001 || f3 == 3'b101) ? {27'd0, in_instr[24:20]} : imm_i;
        dec_we   = 1'b1;
        uses_rs1 = 1'b1;
      end
      OpcLui: begin
        dec_b  = imm_u;
        dec_we = 1'b1;
      end
      OpcAuipc: begin
        dec_a  = in_pc;
        dec_b  = imm_u;
        dec_we = 1'b1;
      end
      OpcJal, OpcJalr: begin
        // ALU produces the link value; target computation lives elsewhere.
        dec_a  = in_pc;
        dec_b  = 32'd4;
        dec_we = 1'b1;
      end
      OpcLoad: begin
        dec_a    = src1;
        dec_b    = imm_i;
        dec_we   = 1'b1;
        uses_rs1 = 1'b1;
      end
      OpcStore: begin
        dec_a    = src1;
        dec_b    = imm_s;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OpcBranch: begin
        if (f3 == 3'b010 || f3 == 3'b011) begin
          dec_illegal = 1'b1;
        end else begin
          dec_op     = {2'b10, f3};
          dec_a      = src1;
          dec_b      = src2;
          dec_branch = 1'b1;
          uses_rs1   = 1'b1;
          uses_rs2   = 1'b1;
        end
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Load-use: the loaded value is not forwardable until the load reaches MEM.
  assign hazard = ex_load_valid && (ex_load_rd != 5'd0) &&
                  ((uses_rs1 && rs1_idx == ex_load_rd) || (uses_rs2 && rs2_idx == ex_load_rd));

  assign in_ready = (!out_valid || out_ready) && !hazard && rst_n;

  // ID/EX pipeline register: reset, flush, load, drain to bubble, or hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_alu_op     <= 5'd0;
      out_alu_a      <= 32'd0;
      out_alu_b      <= 32'd0;
      out_store_data <= 32'd0;
      out_rd         <= 5'd0;
      out_rd_we      <= 1'b0;
      out_pc         <= RESET_PC;
      out_is_branch  <= 1'b0;
      out_illegal    <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid      <= 1'b1;
      out_alu_op     <= dec_op;
      out_alu_a      <= dec_a;
      out_alu_b      <= dec_b;
      out_store_data <= src2;
      out_rd         <= rd_idx;
      out_rd_we      <= dec_we && (rd_idx != 5'd0);
      out_pc         <= in_pc;
      out_is_branch  <= dec_branch;
      out_illegal    <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_id_ex_stage.sv
// Directed bench for rv32i_id_ex_stage with hand-computed expectations.
module tb_rv32i_id_ex_stage;

  localparam logic [31:0] RstPc = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        fwd_mem_we;
  logic [4:0]  fwd_mem_rd;
  logic [31:0] fwd_mem_data;
  logic        fwd_wb_we;
  logic [4:0]  fwd_wb_rd;
  logic [31:0] fwd_wb_data;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_alu_op;
  logic [31:0] out_alu_a;
  logic [31:0] out_alu_b;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [31:0] out_pc;
  logic        out_is_branch;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  rv32i_id_ex_stage #(.RESET_PC(RstPc)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .fwd_mem_we(fwd_mem_we), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
    .fwd_wb_we(fwd_wb_we), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_alu_op(out_alu_op),
    .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_rd_we(out_rd_we), .out_pc(out_pc),
    .out_is_branch(out_is_branch), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_pc = 32'h40;
    in_instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    rs1_data = 32'd10; rs2_data = 32'd3;
    fwd_mem_we = 1'b0; fwd_mem_rd = 5'd0; fwd_mem_data = 32'd0;
    fwd_wb_we = 1'b0; fwd_wb_rd = 5'd0; fwd_wb_data = 32'd0;
    ex_load_valid = 1'b0; ex_load_rd = 5'd0; flush = 1'b0; out_ready = 1'b1;

    // Reset held 3 cycles with input offered
    tick(); tick(); tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, RstPc);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_op", {27'd0, out_alu_op}, 32'd0);

    // SUB x3,x1,x2
    rst_n = 1'b1;
    in_instr = r_type(7'h20, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    #1;
    chk("sub_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("sub_valid", {31'd0, out_valid}, 32'd1);
    chk("sub_op", {27'd0, out_alu_op}, 32'b01000);
    chk("sub_a", out_alu_a, 32'd10);
    chk("sub_b", out_alu_b, 32'd3);
    chk("sub_rd", {27'd0, out_rd}, 32'd3);
    chk("sub_we", {31'd0, out_rd_we}, 32'd1);
    chk("sub_pc", out_pc, 32'h40);

    // ADD x5,x1,x2: MEM beats WB
    in_pc = 32'h44;
    in_instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011);
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd1; fwd_mem_data = 32'd7;
    fwd_wb_we = 1'b1; fwd_wb_rd = 5'd1; fwd_wb_data = 32'd9;
    tick();
    chk("fwd_mem_a", out_alu_a, 32'd7);
    chk("fwd_mem_b", out_alu_b, 32'd3);
    chk("fwd_mem_op", {27'd0, out_alu_op}, 32'd0);

    // WB only
    fwd_mem_we = 1'b0;
    tick();
    chk("fwd_wb_a", out_alu_a, 32'd9);

    // Forwarding with rd=0 never matches
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
    tick();
    chk("fwd_rd0_a", out_alu_a, 32'd10);

    // x0 source reads as 0 regardless of regfile; rd=0 kills we
    fwd_mem_we = 1'b0; fwd_wb_we = 1'b0; rs1_data = 32'd55;
    in_instr = r_type(7'h00, 5'd2, 5'd0, 3'b000, 5'd0, 7'b0110011);
    tick();
    chk("x0_a", out_alu_a, 32'd0);
    chk("rd0_we", {31'd0, out_rd_we}, 32'd0);

    // Load-use: x4 loading in EX, ADD x6,x4,x4 must stall one cycle
    ex_load_valid = 1'b1; ex_load_rd = 5'd4;
    in_instr = r_type(7'h00, 5'd4, 5'd4, 3'b000, 5'd6, 7'b0110011);
    #1;
    chk("lu_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("lu_bubble", {31'd0, out_valid}, 32'd0);
    ex_load_valid = 1'b0;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd4; fwd_mem_data = 32'h55;
    #1;
    chk("lu_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("lu_issue_valid", {31'd0, out_valid}, 32'd1);
    chk("lu_issue_rd", {27'd0, out_rd}, 32'd6);
    chk("lu_issue_a", out_alu_a, 32'h55);
    chk("lu_issue_b", out_alu_b, 32'h55);
    fwd_mem_we = 1'b0;

    // BLTU x1,x2 then backpressure for two cycles
    rs1_data = 32'd5; rs2_data = 32'd6; in_pc = 32'h80;
    in_instr = r_type(7'h00, 5'd2, 5'd1, 3'b110, 5'd0, 7'b1100011);
    tick();
    chk("bltu_op", {27'd0, out_alu_op}, 32'b10110);
    chk("bltu_br", {31'd0, out_is_branch}, 32'd1);
    chk("bltu_we", {31'd0, out_rd_we}, 32'd0);
    out_ready = 1'b0; in_pc = 32'h84;
    in_instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd7, 7'b0110011);
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    chk("stall_op", {27'd0, out_alu_op}, 32'b10110);
    chk("stall_pc", out_pc, 32'h80);
    chk("stall_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_in_ready2", {31'd0, in_ready}, 32'd0);

    // Flush kills held instruction
    flush = 1'b1;
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    // Flush again while the stage is ready: offered input is dropped
    out_ready = 1'b1;
    tick();
    chk("flush_drop_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;

    // Opcode 0x7F illegal
    in_instr = {20'h00000, 5'd7, 7'h7f};
    tick();
    chk("ill_valid", {31'd0, out_valid}, 32'd1);
    chk("ill_flag", {31'd0, out_illegal}, 32'd1);
    chk("ill_we", {31'd0, out_rd_we}, 32'd0);
    chk("ill_op", {27'd0, out_alu_op}, 32'd0);

    // BGEU
    in_instr = r_type(7'h00, 5'd2, 5'd1, 3'b111, 5'd0, 7'b1100011);
    tick();
    chk("bgeu_op", {27'd0, out_alu_op}, 32'b10111);
    chk("bgeu_br", {31'd0, out_is_branch}, 32'd1);
    chk("bgeu_ill", {31'd0, out_illegal}, 32'd0);

    // Branch f3=010 illegal
    in_instr = r_type(7'h00, 5'd2, 5'd1, 3'b010, 5'd0, 7'b1100011);
    tick();
    chk("br010_ill", {31'd0, out_illegal}, 32'd1);
    chk("br010_br", {31'd0, out_is_branch}, 32'd0);

    // OP with f7=0x01 illegal
    in_instr = r_type(7'h01, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011);
    tick();
    chk("opf7_ill", {31'd0, out_illegal}, 32'd1);
    chk("opf7_we", {31'd0, out_rd_we}, 32'd0);

    // LUI x9,0x12345
    in_instr = {20'h12345, 5'd9, 7'b0110111};
    tick();
    chk("lui_a", out_alu_a, 32'd0);
    chk("lui_b", out_alu_b, 32'h1234_5000);
    chk("lui_we", {31'd0, out_rd_we}, 32'd1);

    // SRAI x1,x1,3
    rs1_data = 32'h8000_0000;
    in_instr = r_type(7'h20, 5'd3, 5'd1, 3'b101, 5'd1, 7'b0010011);
    tick();
    chk("srai_op", {27'd0, out_alu_op}, 32'b01101);
    chk("srai_b", out_alu_b, 32'd3);
    chk("srai_a", out_alu_a, 32'h8000_0000);

    // ADDI x2,x1,-1 (upper imm bit set, but not a shift: op stays ADD)
    in_instr = {12'hfff, 5'd1, 3'b000, 5'd2, 7'b0010011};
    tick();
    chk("addi_b", out_alu_b, 32'hffff_ffff);
    chk("addi_op", {27'd0, out_alu_op}, 32'd0);

    // AUIPC x5,0x1 at pc 0x200
    in_pc = 32'h200;
    in_instr = {20'h00001, 5'd5, 7'b0010111};
    tick();
    chk("auipc_a", out_alu_a, 32'h200);
    chk("auipc_b", out_alu_b, 32'h1000);

    // JAL x1: link value pc+4
    in_instr = {20'h00000, 5'd1, 7'b1101111};
    tick();
    chk("jal_b", out_alu_b, 32'd4);
    chk("jal_we", {31'd0, out_rd_we}, 32'd1);

    // SW x2,8(x1): store data from rs2, we=0
    rs1_data = 32'h100; rs2_data = 32'hdead_beef;
    in_instr = {7'h00, 5'd2, 5'd1, 3'b010, 5'd8, 7'b0100011};
    tick();
    chk("sw_b", out_alu_b, 32'd8);
    chk("sw_data", out_store_data, 32'hdead_beef);
    chk("sw_we", {31'd0, out_rd_we}, 32'd0);

    // No input: drains to bubble
    in_valid = 1'b0;
    tick();
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
